branch_resolve_unit: RTL
========================

Name: branch_resolve_unit

Overview:
Parametrised successor to the combinational branch-type decoder. It accepts one decoded control-transfer instruction per cycle, evaluates the branch condition on operand values, and computes the target and link address. It returns a registered resolution one cycle later through a valid/ready handshake. It also owns a BHT of 2-bit saturating counters: fetch queries it combinationally, and retiring conditional branches train it. The unit sits between the execute-stage operand read and the PC-redirect logic.

Parameters:
XLEN, 32, datapath width of operands, PC and immediate (>=8)
BHT_DEPTH, 16, number of 2-bit counters; power of two, >=2
BHT_IDX_W, $clog2(BHT_DEPTH), derived index width; do not override

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  instruction presented
in_ready  output  1  unit can accept
branch  input  1  conditional branch (funct3 selects condition)
jal  input  1  direct jump
jalr  input  1  indirect jump
funct3  input  3  instruction[14:12]
pc  input  XLEN  instruction PC
imm  input  XLEN  sign-extended immediate
rs1_val  input  XLEN  operand 1
rs2_val  input  XLEN  operand 2
pred_taken  input  1  prediction fetch used for this instruction
out_valid  output  1  resolution available
out_ready  input  1  consumer accepts resolution
taken  output  1  resolved direction
target  output  XLEN  taken target
link  output  XLEN  pc+4 (rd write value for jal/jalr)
redirect_pc  output  XLEN  taken ? target : pc+4
mispredict  output  1  fetch must redirect
illegal  output  1  branch with funct3 010/011
lookup_pc  input  XLEN  fetch-side query PC
lookup_taken  output  1  BHT prediction for lookup_pc

Behaviour:
- Clock is clk. Reset rst is asynchronous, active-high. While rst is asserted: out_valid=0, taken=0, mispredict=0, illegal=0, target/link/redirect_pc=0, and every BHT counter=2'b01 (weakly not-taken).
- Handshake: in_ready = !out_valid || out_ready, combinational. Capture occurs when in_valid && in_ready. Latency is exactly 1 cycle: out_valid rises on the edge after capture.
- While out_valid && !out_ready, all outputs hold stable and nothing new is captured.
- If an input is accepted in the same cycle the output is drained, the next edge presents the new result with no bubble.
- An edge with neither capture nor drain leaves state unchanged. Drain without capture clears out_valid.
- A captured instruction with none of branch/jal/jalr set produces out_valid with taken=0, mispredict=0, illegal=0.
- Priority when several type flags are set: jalr > jal > branch.
- Conditions, selected by funct3 on branch: 000 eq; 001 ne; 100 signed lt; 101 signed ge; 110 unsigned lt; 111 unsigned ge.
- funct3 010/011 on branch: taken=0, illegal=1, mispredict=pred_taken, no BHT update.
- Targets: branch/jal target = pc+imm; jalr target = (rs1_val+imm) with bit0 cleared. All adds wrap modulo 2^XLEN. link = pc+4, also wrapping.
- jal and jalr: taken=1. jal: mispredict=!pred_taken. jalr: mispredict=1 always (no target prediction).
- Conditional branch: mispredict = taken ^ pred_taken.
- BHT index = PC[BHT_IDX_W+1:2]. lookup_taken = counter[idx(lookup_pc)][1], combinational.
- BHT update happens on the output handshake (out_valid && out_ready) for a legal conditional branch only: saturating +1 if taken, -1 if not. 11 stays 11; 00 stays 00.
- A lookup to the index being updated in the same cycle returns the pre-update value.
- Reset mid-operation discards any held result; no BHT update occurs for it.

Optional Feature:
BRU_STATS_EN
- Defined: adds output ports stat_branches[31:0] and stat_mispredicts[31:0]. Both reset to 0 and increment on each output handshake of any branch/jal/jalr and of any mispredicting one respectively. Both saturate at 32'hFFFF_FFFF.
- Not defined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then lookup_pc=0x40 -> lookup_taken=0 for all indices; out_valid=0; in_ready=1.
- branch, funct3=100, rs1=0xFFFF_FFFF, rs2=1, pc=0x100, imm=0x20, pred=0 -> next cycle taken=1, target=0x120, redirect_pc=0x120, mispredict=1. After handshake, idx 0 counter goes 01->10 and lookup_pc=0x100 gives 1.
- Same operands with funct3=110 -> taken=0, redirect_pc=0x104, mispredict=0. Counter for idx 0 goes 01->00 and then stays 00 on repeat.
- jalr, rs1=0x1003, imm=0x10, pc=0x200, pred=1 -> target=0x1012, link=0x204, taken=1, mispredict=1, no BHT change.
- Back-pressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable. Release -> next instruction appears the following cycle without a bubble.
- funct3=011 with branch=1, pred=1 -> illegal=1, taken=0, mispredict=1, counter unchanged. Assert rst while out_valid=1 -> out_valid=0 immediately, BHT back to 01.

Source files
------------

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit
// Purpose  : Resolves one decoded control-transfer instruction per cycle.
//            It evaluates the branch condition, computes the target and link
//            address, and returns a registered resolution one cycle later
//            through a valid/ready handshake. The unit also owns a branch
//            history table (BHT) of 2-bit saturating counters. Fetch queries
//            the BHT combinationally, and retiring legal conditional branches
//            train it.
// Ports    : clk, rst (async, active-high)
//            in_valid/in_ready   - instruction handshake
//            branch/jal/jalr     - type flags (jalr > jal > branch)
//            funct3, pc, imm, rs1_val, rs2_val, pred_taken - instruction data
//            out_valid/out_ready - resolution handshake
//            taken, target, link, redirect_pc, mispredict, illegal - result
//            lookup_pc/lookup_taken - fetch-side BHT query
//            stat_branches, stat_mispredicts - only when BRU_STATS_EN
// Options  : `define BRU_STATS_EN to add saturating statistic counters.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 16,
    parameter int BHT_IDX_W = $clog2(BHT_DEPTH)  // derived, do not override
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            branch,
    input  logic            jal,
    input  logic            jalr,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic            pred_taken,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            taken,
    output logic [XLEN-1:0] target,
    output logic [XLEN-1:0] link,
    output logic [XLEN-1:0] redirect_pc,
    output logic            mispredict,
    output logic            illegal,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            lookup_taken
`ifdef BRU_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam logic [XLEN-1:0] c_four     = XLEN'(4);
    localparam logic [1:0]      c_bht_init = 2'b01;  // weakly not-taken

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic r_valid;
    logic w_capture;
    logic w_drain;

    assign in_ready  = !r_valid || out_ready;
    assign w_capture = in_valid && in_ready;
    assign w_drain   = r_valid && out_ready;

    // ------------------------------------------------------------------
    // Combinational resolution of the presented instruction
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_pc_imm;
    logic [XLEN-1:0] w_jalr_sum;
    logic [XLEN-1:0] w_jalr_target;
    logic [XLEN-1:0] w_link;
    logic            w_cond;
    logic            w_taken;
    logic            w_misp;
    logic            w_illegal;
    logic            w_upd;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_redirect;

    assign w_pc_imm      = pc + imm;
    assign w_jalr_sum    = rs1_val + imm;
    assign w_jalr_target = {w_jalr_sum[XLEN-1:1], 1'b0};
    assign w_link        = pc + c_four;

    always_comb begin
        w_cond = 1'b0;
        case (funct3)
            3'b000:  w_cond = (rs1_val == rs2_val);
            3'b001:  w_cond = (rs1_val != rs2_val);
            3'b100:  w_cond = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  w_cond = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  w_cond = (rs1_val <  rs2_val);
            3'b111:  w_cond = (rs1_val >= rs2_val);
            default: w_cond = 1'b0;
        endcase
    end

    always_comb begin
        w_taken   = 1'b0;
        w_misp    = 1'b0;
        w_illegal = 1'b0;
        w_upd     = 1'b0;
        w_target  = w_pc_imm;
        if (jalr) begin
            // No target prediction exists, so an indirect jump always redirects.
            w_taken  = 1'b1;
            w_misp   = 1'b1;
            w_target = w_jalr_target;
        end else if (jal) begin
            w_taken = 1'b1;
            w_misp  = !pred_taken;
        end else if (branch) begin
            if (funct3 == 3'b010 || funct3 == 3'b011) begin
                w_illegal = 1'b1;
                w_misp    = pred_taken;
            end else begin
                w_taken = w_cond;
                w_misp  = w_cond ^ pred_taken;
                w_upd   = 1'b1;
            end
        end
    end

    assign w_redirect = w_taken ? w_target : w_link;

    // ------------------------------------------------------------------
    // Result register
    // ------------------------------------------------------------------
    logic                 r_taken;
    logic [XLEN-1:0]      r_target;
    logic [XLEN-1:0]      r_link;
    logic [XLEN-1:0]      r_redirect;
    logic                 r_misp;
    logic                 r_illegal;
    logic                 r_upd;
    logic [BHT_IDX_W-1:0] r_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_taken    <= 1'b0;
            r_target   <= '0;
            r_link     <= '0;
            r_redirect <= '0;
            r_misp     <= 1'b0;
            r_illegal  <= 1'b0;
            r_upd      <= 1'b0;
            r_idx      <= '0;
        end else if (w_capture) begin
            r_valid    <= 1'b1;
            r_taken    <= w_taken;
            r_target   <= w_target;
            r_link     <= w_link;
            r_redirect <= w_redirect;
            r_misp     <= w_misp;
            r_illegal  <= w_illegal;
            r_upd      <= w_upd;
            r_idx      <= pc[BHT_IDX_W+1:2];
        end else if (w_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid   = r_valid;
    assign taken       = r_taken;
    assign target      = r_target;
    assign link        = r_link;
    assign redirect_pc = r_redirect;
    assign mispredict  = r_misp;
    assign illegal     = r_illegal;

    // ------------------------------------------------------------------
    // Branch history table
    // Training happens when the result retires, so a result discarded by
    // reset never touches the table.
    // ------------------------------------------------------------------
    logic [1:0] r_bht [BHT_DEPTH];
    logic       w_bht_we;
    logic [1:0] w_bht_cur;
    logic [1:0] w_bht_next;

    assign w_bht_we  = w_drain && r_upd;
    assign w_bht_cur = r_bht[r_idx];

    always_comb begin
        w_bht_next = w_bht_cur;
        if (r_taken) begin
            if (w_bht_cur != 2'b11) w_bht_next = w_bht_cur + 2'b01;
        end else begin
            if (w_bht_cur != 2'b00) w_bht_next = w_bht_cur - 2'b01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                r_bht[i] <= c_bht_init;
            end
        end else if (w_bht_we) begin
            r_bht[r_idx] <= w_bht_next;
        end
    end

    // The read sees the registered table, so a same-cycle update to the same
    // index returns the pre-update value.
    assign lookup_taken = r_bht[lookup_pc[BHT_IDX_W+1:2]][1];

    // Only the index field of the lookup PC is meaningful.
    logic w_unused_lookup;
    assign w_unused_lookup = ^lookup_pc;

`ifdef BRU_STATS_EN
    // ------------------------------------------------------------------
    // Saturating statistics
    // ------------------------------------------------------------------
    localparam logic [31:0] c_stat_max = 32'hFFFF_FFFF;

    logic        r_cti;
    logic [31:0] r_stat_br;
    logic [31:0] r_stat_mp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cti <= 1'b0;
        end else if (w_capture) begin
            r_cti <= branch || jal || jalr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_br <= '0;
            r_stat_mp <= '0;
        end else if (w_drain && r_cti) begin
            if (r_stat_br != c_stat_max) r_stat_br <= r_stat_br + 32'd1;
            if (r_misp && r_stat_mp != c_stat_max) r_stat_mp <= r_stat_mp + 32'd1;
        end
    end

    assign stat_branches    = r_stat_br;
    assign stat_mispredicts = r_stat_mp;
`endif

endmodule
`default_nettype wire
